// File: rtl/ospfb_pkg.sv
// Shared types and constants for the OSPFB back-end blocks.
// Holds the integrator FSM encoding and AXIS field widths.
package ospfb_pkg;

    localparam int unsigned TUSER_WID = 8;

    typedef enum logic [0:0] {SYNC, ACCUM} accum_state_t;

    // Narrowest accumulator that cannot wrap when integrating acc_len full-scale powers.
    function automatic int unsigned min_acc_wid(input int unsigned width,
                                                input int unsigned acc_len);
        return 2 * width + 1 + $clog2(acc_len);
    endfunction

endpackage

// File: rtl/power_accum_if.sv
// AXI-Stream in/out bundle plus event pulses for power_accum.
// The slave modport is the DUT side; master is the driving/observing side.
interface power_accum_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ACC_WID = 48
) ();
    import ospfb_pkg::*;

    logic [2*WIDTH-1:0]   s_axis_tdata;
    logic                 s_axis_tvalid;
    logic                 s_axis_tready;
    logic                 s_axis_tlast;
    logic [TUSER_WID-1:0] s_axis_tuser;
    logic [ACC_WID-1:0]   m_axis_tdata;
    logic                 m_axis_tvalid;
    logic                 m_axis_tready;
    logic                 m_axis_tlast;
    logic [TUSER_WID-1:0] m_axis_tuser;
    logic                 event_frame_err;
    logic                 event_overflow;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
               event_frame_err, event_overflow
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, s_axis_tlast, s_axis_tuser, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
               event_frame_err, event_overflow
    );

endinterface

// File: rtl/axis_sync_fifo.sv
// Single-clock FIFO with full/empty flags; a push while full (and not popping) is ignored.
// Read data is forced to zero while empty so the output is clean straight out of reset.
module axis_sync_fifo #(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == (AW + 1)'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign data_o  = empty_o ? '0 : mem[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop)      cnt_q <= cnt_q + (AW + 1)'(1);
            else if (!do_push && do_pop) cnt_q <= cnt_q - (AW + 1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/power_accum.sv
// Squares complex FFT bins, integrates power per channel over ACC_LEN frames and streams
// each finished spectrum out through a 2*FFT_LEN word FIFO; the input is never stalled.
module power_accum
    import ospfb_pkg::*;
#(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned FFT_LEN = 32,
    parameter int unsigned ACC_LEN = 4,
    parameter int unsigned ACC_WID = 48
) (
    input logic          clk,
    input logic          rst,
    power_accum_if.slave bus
);
    localparam int unsigned DW = 2 * WIDTH;
    localparam int unsigned PW = 2 * WIDTH + 1;
    localparam int unsigned CW = $clog2(FFT_LEN);
    localparam int unsigned FW = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam int unsigned TW = CW + 2;
    localparam int unsigned QW = 1 + TUSER_WID + ACC_WID;

    if (ACC_WID < min_acc_wid(WIDTH, ACC_LEN)) begin : g_acc_wid_check
        $error("power_accum: ACC_WID too narrow for WIDTH/ACC_LEN");
    end

    accum_state_t   state_q;
    logic [CW-1:0]  chan_q;
    logic [FW-1:0]  frame_q;
    logic           rdy_q, err_q, ovf_q;
    logic           beat, chan_end, frame_end, bad, take;
    logic signed [WIDTH-1:0] re, im;
    logic signed [DW-1:0]    sq_re, sq_im;

    assign re        = bus.s_axis_tdata[WIDTH-1:0];
    assign im        = bus.s_axis_tdata[DW-1:WIDTH];
    assign sq_re     = DW'(re) * DW'(re);
    assign sq_im     = DW'(im) * DW'(im);
    assign beat      = bus.s_axis_tvalid & rdy_q;
    assign chan_end  = (chan_q == CW'(FFT_LEN - 1));
    assign frame_end = (frame_q == FW'(ACC_LEN - 1));
    assign bad       = (bus.s_axis_tlast != chan_end) ||
                       (bus.s_axis_tuser != TUSER_WID'(chan_q));
    assign take      = beat & (state_q == ACCUM) & ~bad;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SYNC;
            chan_q  <= '0;
            frame_q <= '0;
            rdy_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            err_q <= 1'b0;
            case (state_q)
                SYNC: begin
                    if (beat && bus.s_axis_tlast) begin
                        state_q <= ACCUM;
                        chan_q  <= '0;
                        frame_q <= '0;
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        if (bad) begin
                            err_q   <= 1'b1;
                            state_q <= SYNC;
                            chan_q  <= '0;
                            frame_q <= '0;
                        end else if (chan_end) begin
                            chan_q  <= '0;
                            frame_q <= frame_end ? '0 : frame_q + FW'(1);
                        end else begin
                            chan_q <= chan_q + CW'(1);
                        end
                    end
                end
                default: state_q <= SYNC;
            endcase
        end
    end

    // Tag per stage: {chan, first frame, final frame}; the pipeline free-runs with valid bits.
    logic               v1_q, v2_q, v3_q, v4_q;
    logic [TW-1:0]      tag1_q, tag2_q, tag3_q, tag4_q;
    logic [DW-1:0]      sq_re_q, sq_im_q;
    logic [PW-1:0]      p2_q, p3_q;
    logic [ACC_WID-1:0] rd3_q, sum4_q;
    logic [ACC_WID-1:0] acc_mem [FFT_LEN];
    logic               push, fifo_full, fifo_empty;
    logic [QW-1:0]      fifo_out;

    assign push = v4_q & tag4_q[0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            v4_q    <= 1'b0;
            tag1_q  <= '0;
            tag2_q  <= '0;
            tag3_q  <= '0;
            tag4_q  <= '0;
            sq_re_q <= '0;
            sq_im_q <= '0;
            p2_q    <= '0;
            p3_q    <= '0;
            sum4_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            v1_q    <= take;
            tag1_q  <= {chan_q, frame_q == '0, frame_end};
            sq_re_q <= sq_re;
            sq_im_q <= sq_im;
            v2_q    <= v1_q;
            tag2_q  <= tag1_q;
            p2_q    <= PW'(sq_re_q) + PW'(sq_im_q);
            v3_q    <= v2_q;
            tag3_q  <= tag2_q;
            p3_q    <= p2_q;
            v4_q    <= v3_q;
            tag4_q  <= tag3_q;
            sum4_q  <= tag3_q[1] ? ACC_WID'(p3_q) : rd3_q + ACC_WID'(p3_q);
            ovf_q   <= push & fifo_full & ~bus.m_axis_tready;
        end
    end

    // Final-frame sums go to the FIFO only; the next integration overwrites that slot.
    always_ff @(posedge clk) begin
        rd3_q <= acc_mem[tag2_q[TW-1:2]];
        if (v4_q && !tag4_q[0]) acc_mem[tag4_q[TW-1:2]] <= sum4_q;
    end

    axis_sync_fifo #(
        .DEPTH (2 * FFT_LEN),
        .WIDTH (QW)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .data_i  ({tag4_q[TW-1:2] == CW'(FFT_LEN - 1), TUSER_WID'(tag4_q[TW-1:2]), sum4_q}),
        .pop_i   (bus.m_axis_tready),
        .data_o  (fifo_out),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign bus.s_axis_tready   = rdy_q;
    assign bus.m_axis_tvalid   = ~fifo_empty;
    assign bus.m_axis_tlast    = fifo_out[QW-1];
    assign bus.m_axis_tuser    = fifo_out[QW-2:ACC_WID];
    assign bus.m_axis_tdata    = fifo_out[ACC_WID-1:0];
    assign bus.event_frame_err = err_q;
    assign bus.event_overflow  = ovf_q;

endmodule

// File: tb/tb_power_accum.sv
// Scoreboard bench for power_accum: table of constant-input integrations plus hand-written
// ramp, frame-error, overflow and mid-frame reset sequences.
module tb_power_accum;
    localparam int unsigned WIDTH   = 16;
    localparam int unsigned FFT_LEN = 32;
    localparam int unsigned ACC_LEN = 4;
    localparam int unsigned ACC_WID = 48;

    logic clk = 1'b0;
    logic rst = 1'b0;

    power_accum_if #(.WIDTH(WIDTH), .ACC_WID(ACC_WID)) bus ();

    power_accum #(
        .WIDTH   (WIDTH),
        .FFT_LEN (FFT_LEN),
        .ACC_LEN (ACC_LEN),
        .ACC_WID (ACC_WID)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic               last;
        logic [7:0]         user;
        logic [ACC_WID-1:0] data;
    } exp_t;

    typedef struct {
        logic signed [15:0] re;
        logic signed [15:0] im;
        longint unsigned    power;
    } vec_t;

    exp_t        sb[$];
    exp_t        mon_e;
    vec_t        vecs[6];
    int          n_cmp = 0, n_fail = 0;
    int unsigned cyc = 0, lat_ref = 0;
    int          n_err = 0, n_ovf = 0, rdy_low = 0, out_words = 0;
    bit          lat_arm = 0, chk_rdy = 0, got;

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.event_frame_err) n_err++;
            if (bus.event_overflow) n_ovf++;
            if (chk_rdy && bus.s_axis_tready !== 1'b1) rdy_low++;
            if (lat_arm && bus.m_axis_tvalid) begin
                check("latency", cyc - lat_ref, 4);
                lat_arm = 0;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) begin
                out_words++;
                got = (sb.size() != 0);
                check("word_expected", got, 1);
                if (got) begin
                    mon_e = sb.pop_front();
                    check("tdata", bus.m_axis_tdata, mon_e.data);
                    check("tuser", bus.m_axis_tuser, mon_e.user);
                    check("tlast", bus.m_axis_tlast, mon_e.last);
                end
            end
        end
    end

    task automatic drive_beat(input logic signed [15:0] re, input logic signed [15:0] im,
                              input logic last, input logic [7:0] user);
        bus.s_axis_tdata  = {im, re};
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tlast  = last;
        bus.s_axis_tuser  = user;
        @(posedge clk);
        #1;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
    endtask

    // A full FIFO drops the word, so no expectation is queued beyond its depth.
    task automatic expect_word(input int c, input longint unsigned v);
        exp_t e;
        if (sb.size() < 2 * FFT_LEN) begin
            e.last = (c == FFT_LEN - 1);
            e.user = 8'(c);
            e.data = ACC_WID'(v);
            sb.push_back(e);
        end
    endtask

    task automatic send_integration(input bit ramp, input logic signed [15:0] re,
                                    input logic signed [15:0] im, input longint unsigned pw,
                                    input bit quiet, input bit lat);
        int o0;
        logic signed [15:0] r, i;
        o0 = out_words;
        for (int f = 0; f < ACC_LEN; f++) begin
            if (quiet && f == ACC_LEN - 1) check("quiet_before_final", out_words - o0, 0);
            for (int c = 0; c < FFT_LEN; c++) begin
                if (ramp) begin
                    r = 16'(c);
                    i = 16'sd0;
                end else begin
                    r = re;
                    i = im;
                end
                if (f == ACC_LEN - 1)
                    expect_word(c, ramp ? longint'(ACC_LEN * c * c) : pw);
                drive_beat(r, i, c == FFT_LEN - 1, 8'(c));
                if (lat && f == ACC_LEN - 1 && c == 0) begin
                    lat_ref = cyc;
                    lat_arm = 1;
                end
            end
        end
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        repeat (8) @(posedge clk);
        #1;
        check(name, sb.size(), 0);
    endtask

    initial begin
        int e0, o0, w0;
        vecs[0] = '{16'sd3,      16'sd4,      64'd100};
        vecs[1] = '{-16'sd32768, -16'sd32768, 64'd8589934592};
        vecs[2] = '{16'sd32767,  -16'sd32768, 64'd8589672452};
        vecs[3] = '{-16'sd5,     16'sd12,     64'd676};
        vecs[4] = '{16'sd0,      16'sd0,      64'd0};
        vecs[5] = '{-16'sd1,     16'sd1,      64'd8};

        bus.s_axis_tdata  = '0;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tlast  = 1'b0;
        bus.s_axis_tuser  = '0;
        bus.m_axis_tready = 1'b1;
        #1 rst = 1'b1;
        #13;
        check("rst_s_tready", bus.s_axis_tready, 0);
        check("rst_m_tvalid", bus.m_axis_tvalid, 0);
        check("rst_m_tdata", bus.m_axis_tdata, 0);
        check("rst_m_tuser", bus.m_axis_tuser, 0);
        check("rst_m_tlast", bus.m_axis_tlast, 0);
        check("rst_events", {bus.event_frame_err, bus.event_overflow}, 0);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("s_tready_after_rst", bus.s_axis_tready, 1);
        chk_rdy = 1;

        drive_beat(16'sd0, 16'sd0, 1'b1, 8'd0);
        for (int v = 0; v < 6; v++)
            send_integration(0, vecs[v].re, vecs[v].im, vecs[v].power, v == 0, v == 0);
        wait_drain("drain_table", 500);
        check("latency_seen", lat_arm, 0);

        send_integration(1, 16'sd0, 16'sd0, 64'd0, 0, 0);
        wait_drain("drain_ramp", 300);

        // tlast at chan 17 in the third frame of an integration
        e0 = n_err;
        for (int f = 0; f < 2; f++)
            for (int c = 0; c < FFT_LEN; c++)
                drive_beat(16'sd7, 16'sd1, c == FFT_LEN - 1, 8'(c));
        for (int c = 0; c < 17; c++) drive_beat(16'sd7, 16'sd1, 1'b0, 8'(c));
        drive_beat(16'sd7, 16'sd1, 1'b1, 8'd17);
        repeat (3) @(posedge clk);
        #1;
        check("frame_err_pulse", n_err - e0, 1);
        drive_beat(16'sd0, 16'sd0, 1'b1, 8'd0);
        send_integration(0, 16'sd3, 16'sd4, 64'd100, 1, 0);
        wait_drain("drain_after_err", 300);
        check("frame_err_once", n_err - e0, 1);

        bus.m_axis_tready = 1'b0;
        o0 = n_ovf;
        repeat (3) send_integration(0, -16'sd5, 16'sd12, 64'd676, 0, 0);
        repeat (10) @(posedge clk);
        #1;
        check("ovf_pulses", n_ovf - o0, 32);
        check("full_tvalid", bus.m_axis_tvalid, 1);
        bus.m_axis_tready = 1'b1;
        wait_drain("drain_overflow", 300);
        check("ovf_after_drain", n_ovf - o0, 32);
        check("s_tready_never_low", rdy_low, 0);

        // Reset mid-frame with a spectrum waiting in the FIFO
        bus.m_axis_tready = 1'b0;
        send_integration(0, 16'sd3, 16'sd4, 64'd100, 0, 0);
        for (int c = 0; c < 10; c++) drive_beat(16'sd1, 16'sd1, 1'b0, 8'(c));
        check("pre_rst_tvalid", bus.m_axis_tvalid, 1);
        chk_rdy = 0;
        #2 rst = 1'b1;
        #1;
        check("async_s_tready", bus.s_axis_tready, 0);
        check("async_m_tvalid", bus.m_axis_tvalid, 0);
        check("async_m_tdata", bus.m_axis_tdata, 0);
        check("async_m_tuser", bus.m_axis_tuser, 0);
        check("async_m_tlast", bus.m_axis_tlast, 0);
        sb.delete();
        bus.m_axis_tready = 1'b1;
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        chk_rdy = 1;
        w0 = out_words;
        for (int c = 0; c < 2 * FFT_LEN; c++) drive_beat(16'sd2, 16'sd2, 1'b0, 8'(c % FFT_LEN));
        repeat (8) @(posedge clk);
        #1;
        check("no_output_before_sync", out_words - w0, 0);
        drive_beat(16'sd0, 16'sd0, 1'b1, 8'd31);
        send_integration(1, 16'sd0, 16'sd0, 64'd0, 1, 0);
        wait_drain("drain_post_rst", 300);
        check("post_rst_words", out_words - w0, FFT_LEN);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, got timeout, want finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
